// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge FIFO drain path.
// Holds the SPI master state encoding and the byte/tick geometry.
package bridge_pkg;

    localparam int BYTE_W         = 8;
    localparam int TICKS_PER_BYTE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK half-period divider: one-cycle tick every CLK_DIV clocks while not cleared.
// The counter wraps at CLK_DIV-1 and restarts from zero whenever clear is high.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = !clear && (div_cnt == DIV_LAST);

endmodule

// File: rtl/spi_drain_master.sv
// SPI master draining a FWFT byte FIFO; back-to-back queued bytes share one cs_n burst.
// Define SPI_MODE_SEL_EN to add cpol/cpha inputs; otherwise the bus runs in mode 0 only.
module spi_drain_master
    import bridge_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SPI_MODE_SEL_EN
    input  logic              cpol,
    input  logic              cpha,
`endif
    input  logic              enable,
    input  logic [BYTE_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_GAP)) + 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        bit_cnt;
    logic [BYTE_W-1:0] shift_reg;
    logic [BYTE_W-1:0] rx_sr;
    logic              mode_cpol;
    logic              mode_cpha;
    logic              start_cpol;
    logic              start_cpha;

`ifdef SPI_MODE_SEL_EN
    assign start_cpol = cpol;
    assign start_cpha = cpha;
`else
    assign start_cpol = 1'b0;
    assign start_cpha = 1'b0;
`endif

    logic tick;
    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state != SHIFT),
        .tick  (tick)
    );

    // Odd ticks (bit_cnt even) are the first edge of a bit; cpha picks which edge samples.
    logic              start;
    logic              first_edge;
    logic              sample_now;
    logic              last_tick;
    logic [BYTE_W-1:0] rx_next;

    assign start      = enable && !fifo_empty;
    assign first_edge = !bit_cnt[0];
    assign sample_now = first_edge ^ mode_cpha;
    assign last_tick  = (bit_cnt == 4'(TICKS_PER_BYTE - 1));
    assign rx_next    = {rx_sr[BYTE_W-2:0], spi_miso};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_sr      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            fifo_rd_en <= 1'b0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            mode_cpol  <= 1'b0;
            mode_cpha  <= 1'b0;
        end else begin
            // NOTE: strobes default low here so any assignment below lasts exactly one cycle.
            fifo_rd_en <= 1'b0;
            rx_valid   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= SETUP;
                    cnt       <= '0;
                    busy      <= 1'b1;
                    spi_cs_n  <= 1'b0;
                    mode_cpol <= start_cpol;
                    mode_cpha <= start_cpha;
                    spi_sclk  <= start_cpol;
                end
                SETUP: if (cnt == SETUP_LAST) begin
                    state      <= LOAD;
                    cnt        <= '0;
                    fifo_rd_en <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                LOAD: begin
                    shift_reg <= fifo_rd_data;
                    spi_mosi  <= fifo_rd_data[BYTE_W-1];
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                end
                SHIFT: if (tick) begin
                    bit_cnt  <= bit_cnt + 4'd1;
                    spi_sclk <= first_edge ? ~mode_cpol : mode_cpol;
                    if (sample_now) begin
                        rx_sr <= rx_next;
                    end else begin
                        spi_mosi  <= mode_cpha ? shift_reg[BYTE_W-1] : shift_reg[BYTE_W-2];
                        shift_reg <= shift_reg << 1;
                    end
                    if (last_tick) begin
                        rx_data  <= sample_now ? rx_next : rx_sr;
                        rx_valid <= 1'b1;
                        if (start) begin
                            state      <= LOAD;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= HOLD;
                            cnt   <= '0;
                        end
                    end
                end
                HOLD: if (cnt == HOLD_LAST) begin
                    state    <= GAP;
                    cnt      <= '0;
                    spi_cs_n <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                GAP: if (cnt == GAP_LAST) begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_drain_master.sv
// Directed bench for spi_drain_master with a queue-based FWFT FIFO and MOSI->MISO loopback.
// Build with SPI_MODE_SEL_EN defined to also exercise cpol=1/cpha=1.
`timescale 1ns/1ps
module tb_spi_drain_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_GAP   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_cs_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       miso_inv = 1'b0;
`ifdef SPI_MODE_SEL_EN
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
`endif

    assign spi_miso = spi_mosi ^ miso_inv;

    always #5 clk = ~clk;

    spi_drain_master #(
        .CLK_DIV  (CLK_DIV),
        .CS_SETUP (CS_SETUP),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SPI_MODE_SEL_EN
        .cpol         (cpol),
        .cpha         (cpha),
`endif
        .enable       (enable),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_cs_n     (spi_cs_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy)
    );

    // FWFT FIFO model: head and empty flag refresh on every clock edge.
    logic [7:0] fifo_q[$];
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_empty   <= (fifo_q.size() == 0);
        fifo_rd_data <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         n_rise, n_rden, n_rx, n_csfall, n_csrise, n_bad_sclk;
    int         rd_cyc, rx_cyc, csfall_cyc, csrise_cyc, cs_high_len;
    logic [7:0] mosi_bits;
    logic [7:0] rx_log[$];
    logic       prev_sclk = 1'b0;
    logic       prev_cs   = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (spi_sclk && !prev_sclk) begin
            n_rise++;
            mosi_bits = {mosi_bits[6:0], spi_mosi};
        end
        if (fifo_rd_en) begin
            n_rden++;
            rd_cyc = cyc;
        end
        if (rx_valid) begin
            n_rx++;
            rx_cyc = cyc;
            rx_log.push_back(rx_data);
        end
        if (!spi_cs_n && prev_cs) begin
            n_csfall++;
            csfall_cyc  = cyc;
            cs_high_len = cyc - csrise_cyc;
        end
        if (spi_cs_n && !prev_cs) begin
            n_csrise++;
            csrise_cyc = cyc;
        end
        if (spi_cs_n && spi_sclk != prev_sclk) n_bad_sclk++;
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_rise = 0; n_rden = 0; n_rx = 0; n_csfall = 0; n_csrise = 0; n_bad_sclk = 0;
        rd_cyc = 0; rx_cyc = 0; csfall_cyc = 0; cs_high_len = 0;
        mosi_bits = 8'h00;
        rx_log.delete();
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_log.size()) ? {24'd0, rx_log[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        repeat (3) step();
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_rises(input string tag, input int target, input int budget);
        int n = 0;
        while (n_rise < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_rises_reached"}, n_rise, target);
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int n = 0;
        while (n_rx < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_rx_reached"}, n_rx, target);
    endtask

    initial begin
        int viol;
        csrise_cyc = 0;
        clear_mon();

        // Reset values.
        step();
        step();
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // Single byte 0xA5 with loopback.
        clear_mon();
        push(8'hA5);
        enable = 1'b1;
        wait_idle("t1", 300);
        check("t1_sclk_rises", n_rise, 8);
        check("t1_mosi_bits", mosi_bits, 8'hA5);
        check("t1_rd_en_pulses", n_rden, 1);
        check("t1_rx_count", n_rx, 1);
        check("t1_rx_data", rx_at(0), 8'hA5);
        check("t1_load_to_rx", rx_cyc - rd_cyc, 33);
        check("t1_csfall_to_load", rd_cyc - csfall_cyc, CS_SETUP);
        check("t1_cs_windows", n_csfall, 1);
        check("t1_rx_to_cs_rise", csrise_cyc - rx_cyc, CLK_DIV);
        check("t1_sclk_outside_cs", n_bad_sclk, 0);

        // Three bytes queued before enable form one burst.
        enable = 1'b0;
        step();
        clear_mon();
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        repeat (4) step();
        enable = 1'b1;
        wait_idle("t2", 600);
        check("t2_cs_windows", n_csfall, 1);
        check("t2_sclk_rises", n_rise, 24);
        check("t2_rd_en_pulses", n_rden, 3);
        check("t2_rx_count", n_rx, 3);
        check("t2_rx0", rx_at(0), 8'h01);
        check("t2_rx1", rx_at(1), 8'h80);
        check("t2_rx2", rx_at(2), 8'hFF);
        check("t2_rx_to_cs_rise", csrise_cyc - rx_cyc, CLK_DIV);

        // Empty FIFO with enable held high.
        clear_mon();
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0 || fifo_rd_en !== 1'b0 || busy !== 1'b0) viol++;
        end
        check("t3_idle_violations", viol, 0);
        check("t3_rd_en_pulses", n_rden, 0);

        // Enable drops at bit 3 of 0x3C with a second byte queued.
        clear_mon();
        push(8'h3C);
        push(8'h77);
        wait_rises("t4", 3, 300);
        enable = 1'b0;
        wait_idle("t4", 300);
        check("t4_rx_count", n_rx, 1);
        check("t4_rx0", rx_at(0), 8'h3C);
        check("t4_sclk_rises", n_rise, 8);
        check("t4_rd_en_pulses", n_rden, 1);
        check("t4_fifo_left", fifo_q.size(), 1);
        repeat (20) step();
        check("t4_no_pop_disabled", n_rden, 1);
        check("t4_busy_disabled", busy, 1'b0);
        enable = 1'b1;
        wait_rx("t4b", 2, 300);
        wait_idle("t4b", 300);
        check("t4_rx1", rx_at(1), 8'h77);
        check("t4_cs_windows", n_csfall, 2);

        // Refill during HOLD starts a new burst after the gap.
        clear_mon();
        push(8'h11);
        wait_rx("t5", 1, 300);
        push(8'h22);
        wait_rx("t5b", 2, 300);
        wait_idle("t5", 300);
        check("t5_cs_windows", n_csfall, 2);
        check("t5_cs_high_len", cs_high_len, CS_GAP + 1);
        check("t5_rx1", rx_at(1), 8'h22);
        check("t5_rd_en_pulses", n_rden, 2);

        // Asynchronous reset at bit 5.
        clear_mon();
        push(8'h96);
        push(8'h42);
        wait_rises("t6", 5, 300);
        rst_n = 1'b0;
        #1;
        check("t6_cs_n_async", spi_cs_n, 1'b1);
        check("t6_sclk_async", spi_sclk, 1'b0);
        check("t6_rx_valid_async", rx_valid, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        clear_mon();
        wait_rx("t6b", 1, 300);
        wait_idle("t6b", 300);
        check("t6_rx0", rx_at(0), 8'h42);
        check("t6_rd_en_pulses", n_rden, 1);
        check("t6_cs_windows", n_csfall, 1);
        check("t6_sclk_rises", n_rise, 8);

`ifdef SPI_MODE_SEL_EN
        // Mode 3 with an inverting slave: 0x5A out, 0xA5 back.
        clear_mon();
        cpol = 1'b1;
        cpha = 1'b1;
        miso_inv = 1'b1;
        push(8'h5A);
        wait_rx("t7", 1, 300);
        wait_idle("t7", 300);
        check("t7_rx0", rx_at(0), 8'hA5);
        check("t7_mosi_bits", mosi_bits, 8'h5A);
        check("t7_sclk_rises", n_rise, 8);
        check("t7_sclk_idle_high", spi_sclk, 1'b1);
        check("t7_sclk_outside_cs", n_bad_sclk, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
